// File: rtl/lut_frac_srl_ff2.sv
// lut_frac_srl_ff2: K-input frame-configured LUT that can be fractured into
// two (K-1)-input halves.  Each half has an optional output flop with enable
// and synchronous set/reset.  A carry-majority output is provided.
// Optional feature macro: LUT_SRL_EN builds the shift-register (SRL) mode,
// in which the truth table becomes a 2^K-deep UserCLK delay line.
module lut_frac_srl_ff2 #(
  parameter int K            = 4,
  parameter int NoConfigBits = (2**K) + 7
) (
  input  logic                    UserCLK,
  input  logic                    RESETn,
  input  logic [K-1:0]            I,
  input  logic                    Ci,
  output logic                    Co,
  input  logic                    SR,
  input  logic                    EN,
  input  logic                    SRL_D,
  output logic                    O_A,
  output logic                    O_B,
  output logic                    SRL_Q,
  input  logic [NoConfigBits-1:0] ConfigBits
);

  localparam int N = 2**K;

  logic [N-1:0] init_tbl;
  logic         ff_a_cfg;
  logic         ff_b_cfg;
  logic         i0mux_cfg;
  logic         setv_a;
  logic         setv_b;
  logic         frac_cfg;
  logic         srl_cfg;

  assign init_tbl  = ConfigBits[N-1:0];
  assign ff_a_cfg  = ConfigBits[N];
  assign ff_b_cfg  = ConfigBits[N+1];
  assign i0mux_cfg = ConfigBits[N+2];
  assign setv_a    = ConfigBits[N+3];
  assign setv_b    = ConfigBits[N+4];
  assign frac_cfg  = ConfigBits[N+5];
  assign srl_cfg   = ConfigBits[N+6];

  logic [N-1:0] tbl;
  logic [K-1:0] idx;
  logic [K-1:0] idx_lo;
  logic [K-1:0] idx_hi;
  logic         la;
  logic         lb;
  logic         fa;
  logic         fb;

`ifdef LUT_SRL_EN
  logic [N-1:0] mem;

  // Shift chain: reload INIT on reset, shift newest bit into position 0 on EN.
  always_ff @(posedge UserCLK) begin
    if (!RESETn) begin
      mem <= init_tbl;
    end else if (srl_cfg && EN) begin
      mem <= {mem[N-2:0], SRL_D};
    end
  end

  assign tbl   = srl_cfg ? mem : init_tbl;
  assign SRL_Q = srl_cfg ? mem[N-1] : 1'b0;
`else
  // SRL bit and shift input stay in the port/bitstream layout but do nothing.
  logic unused_srl;
  assign unused_srl = &{1'b0, srl_cfg, SRL_D};
  assign tbl        = init_tbl;
  assign SRL_Q      = 1'b0;
`endif

  // LUT index and half selection; fractured halves ignore I[K-1].
  always_comb begin
    idx    = {I[K-1:1], (i0mux_cfg ? Ci : I[0])};
    idx_lo = {1'b0, idx[K-2:0]};
    idx_hi = {1'b1, idx[K-2:0]};
    if (frac_cfg) begin
      la = tbl[idx_lo];
      lb = tbl[idx_hi];
    end else begin
      la = tbl[idx];
      lb = tbl[idx];
    end
  end

  assign Co = (Ci & I[1]) | (Ci & I[2]) | (I[1] & I[2]);

  // Output flops: reset, then enable, then synchronous set/reset, then load.
  always_ff @(posedge UserCLK) begin
    if (!RESETn) begin
      fa <= setv_a;
      fb <= setv_b;
    end else if (EN) begin
      if (SR) begin
        fa <= setv_a;
        fb <= setv_b;
      end else begin
        fa <= la;
        fb <= lb;
      end
    end
  end

  assign O_A = ff_a_cfg ? fa : la;
  assign O_B = ff_b_cfg ? fb : lb;

endmodule

// File: tb/tb_lut_frac_srl_ff2.sv
// Directed bench for lut_frac_srl_ff2 (K=4).  The SRL section is selected by
// LUT_SRL_EN so the same bench covers both builds.
module tb_lut_frac_srl_ff2;

  logic        UserCLK;
  logic        RESETn;
  logic [3:0]  I;
  logic        Ci;
  logic        Co;
  logic        SR;
  logic        EN;
  logic        SRL_D;
  logic        O_A;
  logic        O_B;
  logic        SRL_Q;
  logic [22:0] ConfigBits;

  int unsigned total;
  int unsigned bad;

  lut_frac_srl_ff2 #(.K(4), .NoConfigBits(23)) dut (
    .UserCLK   (UserCLK),
    .RESETn    (RESETn),
    .I         (I),
    .Ci        (Ci),
    .Co        (Co),
    .SR        (SR),
    .EN        (EN),
    .SRL_D     (SRL_D),
    .O_A       (O_A),
    .O_B       (O_B),
    .SRL_Q     (SRL_Q),
    .ConfigBits(ConfigBits)
  );

  initial UserCLK = 1'b0;
  always #5 UserCLK = ~UserCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge UserCLK);
    #1;
  endtask

  function automatic logic [22:0] mk(input logic [15:0] init, input logic ffa, input logic ffb,
                                     input logic i0m, input logic sa, input logic sb,
                                     input logic frac, input logic srl);
    return {srl, frac, sb, sa, i0m, ffb, ffa, init};
  endfunction

  logic [3:0]  v;
  logic [15:0] m;

  initial begin
    total = 0;
    bad   = 0;
    RESETn = 1'b0; I = '0; Ci = 1'b0; SR = 1'b0; EN = 1'b0; SRL_D = 1'b0;
    ConfigBits = mk(16'h6996, 0, 0, 0, 0, 0, 0, 0);
    tick();
    RESETn = 1'b1;

    // Plain LUT: parity table, both outputs identical.
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      I = v;
      #1;
      chk("plain_A", O_A, ^v);
      chk("plain_B", O_B, ^v);
    end

    // Fractured: lower half AND3, upper half MAJ3, I[3] irrelevant.
    ConfigBits = mk(16'hE880, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      I = v;
      #1;
      chk("frac_A", O_A, v[0] & v[1] & v[2]);
      chk("frac_B", O_B, (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]));
    end

    // Flops, SETV_A=1 SETV_B=0, fractured table.
    ConfigBits = mk(16'hE880, 1, 1, 0, 1, 0, 1, 0);
    I = 4'b0111; EN = 1'b1; SR = 1'b0; RESETn = 1'b0;
    tick();
    chk("rst_A", O_A, 1'b1);
    chk("rst_B", O_B, 1'b0);
    RESETn = 1'b1;
    tick();
    chk("load_A", O_A, 1'b1);
    chk("load_B", O_B, 1'b1);
    EN = 1'b0;
    for (int i = 0; i < 4; i++) begin
      I = 4'(i);
      tick();
      chk("hold_A", O_A, 1'b1);
      chk("hold_B", O_B, 1'b1);
    end
    EN = 1'b1; SR = 1'b1;
    tick();
    chk("sr_A", O_A, 1'b1);
    chk("sr_B", O_B, 1'b0);
    SR = 1'b0; I = 4'b0011;
    #1;
    chk("pre_A", O_A, 1'b1);
    chk("pre_B", O_B, 1'b0);
    tick();
    chk("lat_A", O_A, 1'b0);
    chk("lat_B", O_B, 1'b1);
    I = 4'b0111; SR = 1'b1; RESETn = 1'b0;
    tick();
    chk("rstpri_A", O_A, 1'b1);
    chk("rstpri_B", O_B, 1'b0);
    RESETn = 1'b1; SR = 1'b0; EN = 1'b0;

    // Carry and I0 mux (parity table, combinational outputs).
    ConfigBits = mk(16'h6996, 0, 0, 1, 0, 0, 0, 0);
    Ci = 1'b1; I = 4'b0010;
    #1;
    chk("co_110", Co, 1'b1);
    chk("mux_idx3", O_A, 1'b0);
    Ci = 1'b1; I = 4'b0000;
    #1;
    chk("co_100", Co, 1'b0);
    chk("mux_idx1", O_A, 1'b1);
    Ci = 1'b0; I = 4'b0001;
    #1;
    chk("mux_i0ign", O_A, 1'b0);
    chk("co_001", Co, 1'b0);
    Ci = 1'b0; I = 4'b0110;
    #1;
    chk("co_011", Co, 1'b1);
    Ci = 1'b0;

`ifdef LUT_SRL_EN
    // SRL mode with INIT=0001; m is the reference chain.
    ConfigBits = mk(16'h0001, 0, 0, 0, 0, 0, 0, 1);
    EN = 1'b1; SRL_D = 1'b0; RESETn = 1'b0;
    tick();
    RESETn = 1'b1;
    m = 16'h0001;
    I = 4'd0;
    #1;
    chk("srl_rst_q", SRL_Q, 1'b0);
    chk("srl_rst_t0", O_A, 1'b1);
    SRL_D = 1'b1;
    tick();
    m = {m[14:0], 1'b1};
    SRL_D = 1'b0;
    for (int e = 2; e <= 17; e++) begin
      if (e == 5 || e == 11) begin
        EN = 1'b0; SRL_D = 1'b1;
        tick();
        tick();
        chk("srl_gap", SRL_Q, m[15]);
        EN = 1'b1; SRL_D = 1'b0;
      end
      tick();
      m = {m[14:0], 1'b0};
      chk("srl_q", SRL_Q, m[15]);
      I = 4'(e - 1);
      #1;
      chk("srl_tbl", O_A, m[4'(e - 1)]);
      if (e == 16) chk("srl_q16", SRL_Q, 1'b1);
      if (e == 17) chk("srl_q17", SRL_Q, 1'b0);
    end
    SRL_D = 1'b1;
    tick();
    tick();
    RESETn = 1'b0;
    tick();
    RESETn = 1'b1; EN = 1'b0;
    I = 4'd0;
    #1;
    chk("srl_rl_t0", O_A, 1'b1);
    I = 4'd1;
    #1;
    chk("srl_rl_t1", O_A, 1'b0);
    chk("srl_rl_q", SRL_Q, 1'b0);
`else
    // SRL build disabled: SRL bit ignored, table stays INIT.
    ConfigBits = mk(16'h6996, 0, 0, 0, 0, 0, 0, 1);
    EN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      SRL_D = ~SRL_D;
      tick();
      chk("nosrl_q", SRL_Q, 1'b0);
    end
    I = 4'd5;
    #1;
    chk("nosrl_t5", O_A, 1'b0);
    I = 4'd1;
    #1;
    chk("nosrl_t1", O_A, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
